calc_sequencer: RTL and testbench
=================================

// Module: calc_sequencer
// PURPOSE
//  Control FSM for the calculator datapath. Accepts operand A, operand B and opcode as a
//  3-beat valid/ready stream and drives load enables for the A, B, OP and RESULT registers.
//  Pulses the ALU start, waits for ALU done with a timeout, then holds the result until acked.
//  Sits between the keypad/input front end and the register+ALU datapath.
// PARAMETERS
//  WORD_LENGTH     8   operand/result width; must match datapath registers
//  OPCODE_W        2   opcode field width, taken from in_data[OPCODE_W-1:0]
//  TIMEOUT_CYCLES  32  max cycles in WAIT for alu_done before error; >=2
// PORTS
//  clk         in   1            rising-edge clock
//  reset       in   1            reset, asynchronous, active-low
//  in_valid    in   1            input beat valid
//  in_data     in   WORD_LENGTH  operand A, operand B, then opcode
//  in_ready    out  1            sequencer accepts a beat this cycle
//  ld_a        out  1            load enable, operand A register
//  ld_b        out  1            load enable, operand B register
//  ld_op       out  1            load enable, opcode register
//  alu_start   out  1            1-cycle ALU start pulse
//  alu_done    in   1            ALU result ready (may be same cycle +1 or later)
//  ld_res      out  1            load enable, result register
//  res_valid   out  1            result register holds a valid result
//  res_ready   in   1            consumer ack of result or error
//  error       out  1            div-by-zero or ALU timeout; held until acked
//  busy        out  1            high in every state except GET_A
// BEHAVIOUR
//  Reset (async, reset==0): state=GET_A, counter=0, b_zero=0; all outputs 0 except in_ready=1.
//  Opcodes: 00 ADD, 01 SUB, 10 MUL, 11 DIV. Upper in_data bits ignored on opcode beat.
//  Beat accepted when in_valid & in_ready. ld_a/ld_b/ld_op are combinational = accept in
//    GET_A/GET_B/GET_OP resp., so the register captures in_data on the same edge.
//  GET_A:   in_ready=1; accept -> GET_B.
//  GET_B:   in_ready=1; accept -> GET_OP; b_zero <= (in_data==0).
//  GET_OP:  in_ready=1; accept: opcode DIV & b_zero -> ERR, else -> EXEC.
//  EXEC:    alu_start=1 for exactly this cycle; -> WAIT; counter<=0.
//  WAIT:    alu_done -> CAPTURE; else counter+1; counter==TIMEOUT_CYCLES-1 w/o done -> ERR.
//           alu_done sampled only in WAIT; done in EXEC is ignored.
//  CAPTURE: ld_res=1 one cycle -> HOLD.
//  HOLD:    res_valid=1; res_ready -> GET_A (res_valid drops next cycle).
//  ERR:     error=1; res_ready -> GET_A. ld_res never asserted on error path.
//  Latency: opcode accept to alu_start = 1 cycle; alu_done to res_valid = 2 cycles.
//  in_ready=0 in EXEC/WAIT/CAPTURE/HOLD/ERR; input beats there are neither lost nor counted.
//  res_ready outside HOLD/ERR ignored. alu_done late after timeout ignored (state ERR).
//  Reset mid-operation: immediate return to GET_A, all enables/pulses deasserted at once.
//  Outputs ld_*, alu_start, res_valid, error, busy are glitch-free decodes of state (+accept).
// STRUCTURE
//  calc_pkg: opcode localparams (OP_ADD..OP_DIV), state enum (GET_A,GET_B,GET_OP,EXEC,
//    WAIT,CAPTURE,HOLD,ERR), shared by ALU and sequencer.
//  Sub-module calc_timeout_ctr: clear/enable counter, $clog2(TIMEOUT_CYCLES) bits, expired flag.
//  Two-process FSM (state register + next-state/output decode) in calc_sequencer.
// TESTING
//  1 A=5,B=3,op=00 back-to-back beats; alu_done 2 cycles after start -> ld_a,ld_b,ld_op one
//    cycle each, single alu_start, ld_res 1 cycle, res_valid until res_ready, then in_ready=1.
//  2 A=9,B=0,op=11 -> no alu_start, error=1 next cycle; held 5 cycles until res_ready; ld_res=0.
//  3 A=9,B=0,op=10 (MUL) -> normal path, no error (zero check only for DIV).
//  4 alu_done never asserted -> error exactly TIMEOUT_CYCLES cycles after entering WAIT.
//  5 in_valid toggling and held high during WAIT/HOLD -> no extra ld_* pulses, in_ready=0.
//  6 reset=0 asserted in WAIT and in HOLD -> outputs clear asynchronously; next op runs clean.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator types: opcode encodings and the sequencer state enum.
// Used by both the ALU and the control sequencer.
package calc_pkg;

  localparam int OPCODE_W = 2;

  typedef logic [OPCODE_W-1:0] opcode_t;

  localparam opcode_t OP_ADD = 2'b00;
  localparam opcode_t OP_SUB = 2'b01;
  localparam opcode_t OP_MUL = 2'b10;
  localparam opcode_t OP_DIV = 2'b11;

  typedef enum logic [2:0] {
    GET_A   = 3'd0,
    GET_B   = 3'd1,
    GET_OP  = 3'd2,
    EXEC    = 3'd3,
    WAIT    = 3'd4,
    CAPTURE = 3'd5,
    HOLD    = 3'd6,
    ERR     = 3'd7
  } calc_state_e;

  function automatic logic is_input_state(input calc_state_e s);
    return (s == GET_A) || (s == GET_B) || (s == GET_OP);
  endfunction

endpackage

// File: rtl/calc_timeout_ctr.sv
// Clear/enable cycle counter bounding how long the sequencer waits for the ALU.
// expired is high while the count sits on its last allowed value.
module calc_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] count_r;

  // Cycle counter; clear has priority over enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {CW{1'b0}};
    end else if (clear) begin
      count_r <= {CW{1'b0}};
    end else if (enable) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/calc_sequencer.sv
// Control FSM for the calculator datapath: collects A, B and opcode beats,
// launches the ALU, bounds the wait for done, and holds result/error until acked.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int WORD_LENGTH    = 8,
  parameter int OPCODE_W       = calc_pkg::OPCODE_W,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [WORD_LENGTH-1:0] in_data,
  output logic                   in_ready,
  output logic                   ld_a,
  output logic                   ld_b,
  output logic                   ld_op,
  output logic                   alu_start,
  input  logic                   alu_done,
  output logic                   ld_res,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic                   error,
  output logic                   busy
);

  calc_state_e         state_r;
  calc_state_e         next_state_s;
  logic                b_zero_r;
  logic                accept_s;
  logic [OPCODE_W-1:0] op_s;
  logic                expired_s;
  logic                ctr_clear_s;
  logic                ctr_en_s;

  logic in_ready_r;
  logic alu_start_r;
  logic ld_res_r;
  logic res_valid_r;
  logic error_r;
  logic busy_r;

  assign accept_s    = in_valid & in_ready_r;
  assign op_s        = in_data[OPCODE_W-1:0];
  assign ctr_clear_s = (state_r == EXEC);
  assign ctr_en_s    = (state_r == WAIT);

  calc_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk     (clk),
    .reset   (reset),
    .clear   (ctr_clear_s),
    .enable  (ctr_en_s),
    .expired (expired_s)
  );

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      GET_A: begin
        if (accept_s) next_state_s = GET_B;
        else          next_state_s = GET_A;
      end
      GET_B: begin
        if (accept_s) next_state_s = GET_OP;
        else          next_state_s = GET_B;
      end
      GET_OP: begin
        if (accept_s && (op_s == OPCODE_W'(OP_DIV)) && b_zero_r) next_state_s = ERR;
        else if (accept_s)                                      next_state_s = EXEC;
        else                                                    next_state_s = GET_OP;
      end
      EXEC:    next_state_s = WAIT;
      WAIT: begin
        if (alu_done)       next_state_s = CAPTURE;
        else if (expired_s) next_state_s = ERR;
        else                next_state_s = WAIT;
      end
      CAPTURE: next_state_s = HOLD;
      HOLD: begin
        if (res_ready) next_state_s = GET_A;
        else           next_state_s = HOLD;
      end
      ERR: begin
        if (res_ready) next_state_s = GET_A;
        else           next_state_s = ERR;
      end
      default: next_state_s = GET_A;
    endcase
  end

  // State, divisor-zero flag and state-decoded outputs, registered from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= GET_A;
      b_zero_r    <= 1'b0;
      in_ready_r  <= 1'b1;
      alu_start_r <= 1'b0;
      ld_res_r    <= 1'b0;
      res_valid_r <= 1'b0;
      error_r     <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if ((state_r == GET_B) && accept_s) begin
        b_zero_r <= (in_data == {WORD_LENGTH{1'b0}});
      end else begin
        b_zero_r <= b_zero_r;
      end
      in_ready_r  <= is_input_state(next_state_s);
      alu_start_r <= (next_state_s == EXEC);
      ld_res_r    <= (next_state_s == CAPTURE);
      res_valid_r <= (next_state_s == HOLD);
      error_r     <= (next_state_s == ERR);
      busy_r      <= (next_state_s != GET_A);
    end
  end

  // Beat loads strobe on the same edge the datapath register captures in_data.
  assign ld_a  = accept_s & (state_r == GET_A);
  assign ld_b  = accept_s & (state_r == GET_B);
  assign ld_op = accept_s & (state_r == GET_OP);

  assign in_ready  = in_ready_r;
  assign alu_start = alu_start_r;
  assign ld_res    = ld_res_r;
  assign res_valid = res_valid_r;
  assign error     = error_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed self-checking bench for calc_sequencer: beat handshake, ALU launch,
// divide-by-zero and timeout errors, ignored inputs and asynchronous reset.
module tb_calc_sequencer;

  localparam int WL = 8;
  localparam int TO = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic [WL-1:0] in_data = '0;
  logic          alu_done = 1'b0;
  logic          res_ready = 1'b0;
  logic in_ready, ld_a, ld_b, ld_op, alu_start, ld_res, res_valid, error, busy;

  int total = 0;
  int bad = 0;
  int n_a = 0, n_b = 0, n_op = 0, n_st = 0, n_res = 0, n_err = 0;

  calc_sequencer #(.WORD_LENGTH(WL), .OPCODE_W(2), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ld_a(ld_a), .ld_b(ld_b), .ld_op(ld_op),
    .alu_start(alu_start), .alu_done(alu_done), .ld_res(ld_res),
    .res_valid(res_valid), .res_ready(res_ready), .error(error), .busy(busy)
  );

  always #5 clk = ~clk;

  // Mid-cycle pulse counters.
  always @(negedge clk) begin
    if (ld_a)      n_a++;
    if (ld_b)      n_b++;
    if (ld_op)     n_op++;
    if (alu_start) n_st++;
    if (ld_res)    n_res++;
    if (error)     n_err++;
  end

  // Drive one cycle's inputs just after the rising edge; return at the falling edge to sample.
  task automatic cyc(input logic v, input logic [WL-1:0] d, input logic dn, input logic rr);
    @(posedge clk);
    #1;
    in_valid = v; in_data = d; alu_done = dn; res_ready = rr;
    @(negedge clk);
  endtask

  task automatic send_op(input logic [WL-1:0] a, input logic [WL-1:0] b, input logic [WL-1:0] op);
    cyc(1'b1, a, 1'b0, 1'b0);
    cyc(1'b1, b, 1'b0, 1'b0);
    cyc(1'b1, op, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({in_ready, ld_a, ld_b, ld_op, alu_start, ld_res, res_valid, error, busy} !== 9'b1_0000_0000) begin
      bad++;
      $display("FAIL reset_state got=%b exp=%b",
               {in_ready, ld_a, ld_b, ld_op, alu_start, ld_res, res_valid, error, busy}, 9'b1_0000_0000);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_add();
    int sa = n_a, sb = n_b, so = n_op, ss = n_st, sr = n_res;
    cyc(1'b1, 8'd5, 1'b0, 1'b0);
    total++; if ({in_ready, ld_a, busy} !== 3'b110) begin bad++; $display("FAIL add_beat_a got=%b exp=110", {in_ready, ld_a, busy}); end
    cyc(1'b1, 8'd3, 1'b0, 1'b0);
    total++; if ({ld_a, ld_b, busy} !== 3'b011) begin bad++; $display("FAIL add_beat_b got=%b exp=011", {ld_a, ld_b, busy}); end
    cyc(1'b1, 8'd0, 1'b0, 1'b0);
    total++; if ({ld_b, ld_op} !== 2'b01) begin bad++; $display("FAIL add_beat_op got=%b exp=01", {ld_b, ld_op}); end
    cyc(1'b0, 8'd0, 1'b0, 1'b0);
    total++; if ({alu_start, in_ready} !== 2'b10) begin bad++; $display("FAIL add_start got=%b exp=10", {alu_start, in_ready}); end
    cyc(1'b0, 8'd0, 1'b0, 1'b0);
    cyc(1'b0, 8'd0, 1'b1, 1'b0);
    total++; if ({alu_start, ld_res, res_valid} !== 3'b000) begin bad++; $display("FAIL add_wait got=%b exp=000", {alu_start, ld_res, res_valid}); end
    cyc(1'b0, 8'd0, 1'b0, 1'b0);
    total++; if ({ld_res, res_valid} !== 2'b10) begin bad++; $display("FAIL add_capture got=%b exp=10", {ld_res, res_valid}); end
    cyc(1'b0, 8'd0, 1'b0, 1'b0);
    cyc(1'b0, 8'd0, 1'b0, 1'b0);
    cyc(1'b0, 8'd0, 1'b0, 1'b1);
    total++; if ({ld_res, res_valid, in_ready} !== 3'b010) begin bad++; $display("FAIL add_hold got=%b exp=010", {ld_res, res_valid, in_ready}); end
    cyc(1'b0, 8'd0, 1'b0, 1'b0);
    total++; if ({res_valid, in_ready, busy} !== 3'b010) begin bad++; $display("FAIL add_done got=%b exp=010", {res_valid, in_ready, busy}); end
    total++;
    if ({n_a - sa, n_b - sb, n_op - so, n_st - ss, n_res - sr} !== {32'd1, 32'd1, 32'd1, 32'd1, 32'd1}) begin
      bad++;
      $display("FAIL add_pulse_counts got a=%0d b=%0d op=%0d start=%0d res=%0d exp all 1",
               n_a - sa, n_b - sb, n_op - so, n_st - ss, n_res - sr);
    end
  endtask

  task automatic test_div_zero();
    int ss = n_st, sr = n_res, held = 0;
    send_op(8'd9, 8'd0, 8'hF3);
    cyc(1'b0, 8'd0, 1'b0, 1'b0);
    total++; if ({error, alu_start, in_ready, busy} !== 4'b1001) begin bad++; $display("FAIL div0_error got=%b exp=1001", {error, alu_start, in_ready, busy}); end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 8'd0, 1'b0, 1'b0);
      if (error === 1'b1) held++;
    end
    cyc(1'b0, 8'd0, 1'b0, 1'b1);
    if (error === 1'b1) held++;
    total++; if (held !== 5) begin bad++; $display("FAIL div0_held got=%0d exp=5", held); end
    cyc(1'b0, 8'd0, 1'b0, 1'b0);
    total++; if ({error, in_ready} !== 2'b01) begin bad++; $display("FAIL div0_ack got=%b exp=01", {error, in_ready}); end
    total++; if ((n_st - ss) !== 0 || (n_res - sr) !== 0) begin bad++; $display("FAIL div0_no_start got start=%0d res=%0d exp 0 0", n_st - ss, n_res - sr); end
  endtask

  task automatic test_mul_zero();
    int se = n_err;
    send_op(8'd9, 8'd0, 8'd2);
    cyc(1'b0, 8'd0, 1'b1, 1'b0);
    total++; if ({alu_start, error} !== 2'b10) begin bad++; $display("FAIL mul0_start got=%b exp=10", {alu_start, error}); end
    cyc(1'b0, 8'd0, 1'b0, 1'b0);
    total++; if (ld_res !== 1'b0) begin bad++; $display("FAIL exec_done_ignored got=%b exp=0", ld_res); end
    cyc(1'b0, 8'd0, 1'b1, 1'b0);
    cyc(1'b0, 8'd0, 1'b0, 1'b0);
    total++; if (ld_res !== 1'b1) begin bad++; $display("FAIL mul0_capture got=%b exp=1", ld_res); end
    cyc(1'b0, 8'd0, 1'b0, 1'b1);
    total++; if ({res_valid, error} !== 2'b10) begin bad++; $display("FAIL mul0_hold got=%b exp=10", {res_valid, error}); end
    cyc(1'b0, 8'd0, 1'b0, 1'b0);
    total++; if ((n_err - se) !== 0) begin bad++; $display("FAIL mul0_no_error got=%0d exp=0", n_err - se); end
  endtask

  task automatic test_timeout();
    int sr = n_res, early = 0;
    send_op(8'd1, 8'd2, 8'd0);
    cyc(1'b0, 8'd0, 1'b0, 1'b0);
    for (int i = 0; i < TO; i++) begin
      cyc(1'b0, 8'd0, 1'b0, 1'b0);
      if (error !== 1'b0 || busy !== 1'b1) early++;
    end
    total++; if (early !== 0) begin bad++; $display("FAIL timeout_early got=%0d exp=0", early); end
    cyc(1'b0, 8'd0, 1'b0, 1'b0);
    total++; if (error !== 1'b1) begin bad++; $display("FAIL timeout_error got=%b exp=1", error); end
    cyc(1'b0, 8'd0, 1'b1, 1'b0);
    cyc(1'b0, 8'd0, 1'b0, 1'b0);
    total++; if ({error, ld_res, res_valid} !== 3'b100) begin bad++; $display("FAIL timeout_late_done got=%b exp=100", {error, ld_res, res_valid}); end
    cyc(1'b0, 8'd0, 1'b0, 1'b1);
    cyc(1'b0, 8'd0, 1'b0, 1'b0);
    total++; if ({error, in_ready, n_res - sr} !== {2'b01, 32'd0}) begin bad++; $display("FAIL timeout_ack got err=%b rdy=%b res=%0d exp 0 1 0", error, in_ready, n_res - sr); end
  endtask

  task automatic test_ignored_inputs();
    int sa = n_a, sb = n_b, so = n_op, ss = n_st, stuck = 0;
    send_op(8'd4, 8'd6, 8'd1);
    cyc(1'b1, 8'hAA, 1'b0, 1'b1);
    if (in_ready !== 1'b0) stuck++;
    for (int i = 0; i < 6; i++) begin
      cyc(i[0], 8'(i), 1'b0, 1'b1);
      if (in_ready !== 1'b0 || error !== 1'b0) stuck++;
    end
    cyc(1'b1, 8'h77, 1'b1, 1'b0);
    cyc(1'b1, 8'h77, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 8'h55, 1'b0, 1'b0);
      if (in_ready !== 1'b0 || res_valid !== 1'b1) stuck++;
    end
    cyc(1'b0, 8'd0, 1'b0, 1'b1);
    cyc(1'b0, 8'd0, 1'b0, 1'b0);
    total++; if (stuck !== 0) begin bad++; $display("FAIL ignore_in_ready got=%0d bad cycles exp=0", stuck); end
    total++;
    if ({n_a - sa, n_b - sb, n_op - so, n_st - ss} !== {32'd1, 32'd1, 32'd1, 32'd1}) begin
      bad++;
      $display("FAIL ignore_pulse_counts got a=%0d b=%0d op=%0d start=%0d exp all 1",
               n_a - sa, n_b - sb, n_op - so, n_st - ss);
    end
  endtask

  task automatic test_reset_mid();
    int sa, sr;
    send_op(8'd2, 8'd2, 8'd0);
    cyc(1'b0, 8'd0, 1'b0, 1'b0);
    cyc(1'b0, 8'd0, 1'b0, 1'b0);
    @(posedge clk); #3 reset = 1'b0; #1;
    total++;
    if ({in_ready, ld_a, ld_b, ld_op, alu_start, ld_res, res_valid, error, busy} !== 9'b1_0000_0000) begin
      bad++;
      $display("FAIL reset_in_wait got=%b exp=%b",
               {in_ready, ld_a, ld_b, ld_op, alu_start, ld_res, res_valid, error, busy}, 9'b1_0000_0000);
    end
    @(negedge clk); reset = 1'b1;
    send_op(8'd1, 8'd1, 8'd2);
    cyc(1'b0, 8'd0, 1'b0, 1'b0);
    cyc(1'b0, 8'd0, 1'b1, 1'b0);
    cyc(1'b0, 8'd0, 1'b0, 1'b0);
    cyc(1'b0, 8'd0, 1'b0, 1'b0);
    total++; if ({res_valid, error} !== 2'b10) begin bad++; $display("FAIL reset_pre_hold got=%b exp=10", {res_valid, error}); end
    @(posedge clk); #3 reset = 1'b0; #1;
    total++;
    if ({in_ready, ld_a, ld_b, ld_op, alu_start, ld_res, res_valid, error, busy} !== 9'b1_0000_0000) begin
      bad++;
      $display("FAIL reset_in_hold got=%b exp=%b",
               {in_ready, ld_a, ld_b, ld_op, alu_start, ld_res, res_valid, error, busy}, 9'b1_0000_0000);
    end
    @(negedge clk); reset = 1'b1;
    sa = n_a; sr = n_res;
    send_op(8'd3, 8'd4, 8'd0);
    cyc(1'b0, 8'd0, 1'b0, 1'b0);
    total++; if (alu_start !== 1'b1) begin bad++; $display("FAIL post_reset_start got=%b exp=1", alu_start); end
    cyc(1'b0, 8'd0, 1'b1, 1'b0);
    cyc(1'b0, 8'd0, 1'b0, 1'b0);
    cyc(1'b0, 8'd0, 1'b0, 1'b1);
    total++; if ({res_valid, error, n_a - sa, n_res - sr} !== {2'b10, 32'd1, 32'd1}) begin
      bad++;
      $display("FAIL post_reset_run got valid=%b err=%b a=%0d res=%0d exp 1 0 1 1", res_valid, error, n_a - sa, n_res - sr);
    end
    cyc(1'b0, 8'd0, 1'b0, 1'b0);
    total++; if ({in_ready, busy} !== 2'b10) begin bad++; $display("FAIL post_reset_idle got=%b exp=10", {in_ready, busy}); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_div_zero();
    test_mul_zero();
    test_timeout();
    test_ignored_inputs();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
